// File: rtl/rr_arbiter_2x1.sv
// Two-requester round-robin arbiter that owns the select of a 2:1 data mux.
// Each grant lasts one burst, ending on a last beat or after MAX_BURST beats.
module rr_arbiter_2x1 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_last,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_sel,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       prio;
    logic       prio_nxt;
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_nxt;
    logic       sel_q;
    logic       sel_nxt;

    logic granted;
    logic gnt_id;
    logic beat_ok;
    logic burst_end;

    assign granted   = (state == GNT0) || (state == GNT1);
    assign gnt_id    = (state == GNT1);
    assign beat_ok   = granted && req_valid[gnt_id] && out_ready;
    assign burst_end = beat_ok && (req_last[gnt_id] || (beat_cnt == LAST_CNT));

    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        beat_cnt_nxt = beat_cnt;
        sel_nxt      = sel_q;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    state_nxt = prio ? GNT1 : GNT0;
                    sel_nxt   = prio;
                end else if (req_valid[0]) begin
                    state_nxt = GNT0;
                    sel_nxt   = 1'b0;
                end else if (req_valid[1]) begin
                    state_nxt = GNT1;
                    sel_nxt   = 1'b1;
                end
            end
            GNT0, GNT1: begin
                // Ending a burst always passes through IDLE so the pointer flip takes effect.
                if (burst_end) begin
                    state_nxt    = IDLE;
                    prio_nxt     = ~gnt_id;
                    beat_cnt_nxt = 4'd0;
                end else if (beat_ok) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= 4'd0;
            sel_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            beat_cnt <= beat_cnt_nxt;
            sel_q    <= sel_nxt;
        end
    end

    // Handshake outputs are gated by rst_n so nothing is accepted in a reset cycle.
    assign busy         = rst_n && granted;
    assign out_valid    = rst_n && granted && req_valid[gnt_id];
    assign req_ready[0] = rst_n && (state == GNT0) && out_ready;
    assign req_ready[1] = rst_n && (state == GNT1) && out_ready;
    assign out_sel      = sel_q;
    assign out_data     = sel_q ? req_data1 : req_data0;

endmodule

// File: tb/tb_rr_arbiter_2x1.sv
// Bench for rr_arbiter_2x1: directed literal checks of the arbitration pattern,
// then randomized traffic compared every cycle against a burst-level model.
module tb_rr_arbiter_2x1;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_last;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_sel;
    logic              busy;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: who owns the channel (-1 none), beats taken in this burst, who wins a tie next.
    int m_owner = -1;
    int m_beats = 0;
    int m_prio  = 0;
    int m_sel   = 0;

    rr_arbiter_2x1 #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [1:0] l,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
        rst_n     = rst;
        req_valid = v;
        req_last  = l;
        req_data0 = d0;
        req_data1 = d1;
        out_ready = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_beats = 0;
            m_prio  = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            if (req_valid == 2'b11)   m_owner = m_prio;
            else if (req_valid[0])    m_owner = 0;
            else if (req_valid[1])    m_owner = 1;
            if (m_owner >= 0) m_sel = m_owner;
        end else if (req_valid[m_owner] && out_ready) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MAX_BURST) begin
                m_prio  = (m_owner == 0) ? 1 : 0;
                m_owner = -1;
                m_beats = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic       e_busy;
            logic       e_valid;
            logic [1:0] e_ready;
            logic [7:0] e_data;
            e_busy  = rst_n && (m_owner >= 0);
            e_valid = e_busy && req_valid[m_owner[0]];
            e_ready = (e_busy && out_ready) ? (2'b01 << m_owner) : 2'b00;
            e_data  = (m_sel == 1) ? req_data1 : req_data0;
            checkOutput("model_busy",      32'(busy),      32'(e_busy));
            checkOutput("model_out_valid", 32'(out_valid), 32'(e_valid));
            checkOutput("model_req_ready", 32'(req_ready), 32'(e_ready));
            checkOutput("model_out_sel",   32'(out_sel),   32'(m_sel));
            checkOutput("model_out_data",  32'(out_data),  32'(e_data));
        end
    end

    initial begin
        logic [1:0] exp_rdy [11];
        logic       exp_sel [11];
        exp_rdy = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
        exp_sel = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (2) nextCycle();
        check_en = 1'b1;

        // Single-beat burst from requester 0.
        applyStimulus(1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 1'b1);
        atSample();
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_out_sel",   32'(out_sel),   32'd0);
        nextCycle();
        atSample();
        checkOutput("single_busy",      32'(busy),      32'd1);
        checkOutput("single_req_ready", 32'(req_ready), 32'h1);
        checkOutput("single_out_data",  32'(out_data),  32'hA5);
        checkOutput("single_out_valid", 32'(out_valid), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 2'b11, 2'b00, 8'h10, 8'h20, 1'b1);
        atSample();
        checkOutput("single_back_idle", 32'(busy), 32'd0);
        checkOutput("single_idle_rdy",  32'(req_ready), 32'd0);

        // Both requesting: prio is 1 after the single burst, so requester 1 leads.
        for (int k = 0; k < 11; k++) begin
            nextCycle();
            atSample();
            checkOutput("rr_req_ready", 32'(req_ready), 32'(exp_rdy[k]));
            checkOutput("rr_out_sel",   32'(out_sel),   32'(exp_sel[k]));
        end

        // Reset during beat 2 of a GNT1 burst.
        nextCycle();
        rst_n = 1'b0;
        atSample();
        checkOutput("rst_mid_busy",  32'(busy),      32'd0);
        checkOutput("rst_mid_rdy",   32'(req_ready), 32'd0);
        checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        atSample();
        checkOutput("rst_after_busy", 32'(busy),    32'd0);
        checkOutput("rst_after_sel",  32'(out_sel), 32'd0);
        nextCycle();
        atSample();
        checkOutput("rst_regrant_rdy", 32'(req_ready), 32'h1);

        // Requester 0 full burst, then requester 1 ends early on beat 2.
        repeat (4) nextCycle();
        atSample();
        checkOutput("early_idle_busy", 32'(busy), 32'd0);
        nextCycle();
        atSample();
        checkOutput("early_beat1_rdy", 32'(req_ready), 32'h2);
        nextCycle();
        req_last = 2'b10;
        atSample();
        checkOutput("early_beat2_rdy", 32'(req_ready), 32'h2);
        nextCycle();
        req_last = 2'b00;
        atSample();
        checkOutput("early_end_busy", 32'(busy), 32'd0);
        nextCycle();
        atSample();
        checkOutput("early_next_gnt0", 32'(req_ready), 32'h1);

        // Random traffic with stalls, bubbles, early lasts and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            nextCycle();
            applyStimulus(($urandom_range(0, 99) != 0),
                          {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                          {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                          8'($urandom), 8'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        atSample();
        nextCycle();
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_2x1.md
Name: rr_arbiter_2x1

Overview:
- Two-requester round-robin arbiter and burst sequencer that owns the select line of a 2:1 data multiplexer.
- Shares one downstream valid/ready channel between requester 0 and requester 1.
- Holds each grant for one burst, which ends on a last beat or at MAX_BURST beats.
- Drives the mux select, the per-requester ready signals and the shared output; sits directly in front of the 2:1 mux datapath.

Parameters:
- DATA_W, 8, width of each requester's data and of out_data.
- MAX_BURST, 4, maximum beats accepted per grant (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  2  bit i: requester i has a beat.
- req_last  input  2  bit i: requester i's current beat ends its burst.
- req_data0  input  DATA_W  requester 0 data.
- req_data1  input  DATA_W  requester 1 data.
- req_ready  output  2  bit i: requester i's beat is accepted this cycle.
- out_valid  output  1  shared channel valid.
- out_data  output  DATA_W  muxed data.
- out_ready  input  1  downstream accept.
- out_sel  output  1  mux select (0 = requester 0, 1 = requester 1).
- busy  output  1  a grant is active.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Clock and reset port names are clk and rst_n.
- States: IDLE, GNT0, GNT1; state is registered.
- Priority pointer prio is a 1-bit register.
- Beat counter beat_cnt is 4 bits.
- Reset (rst_n low at a rising edge) sets:
  - state = IDLE, prio = 0, beat_cnt = 0, out_sel = 0.
  - Resulting outputs: busy = 0, out_valid = 0, req_ready = 2'b00.
  - Reset asserted mid-burst aborts the burst. No beat is accepted in the reset cycle: outputs are gated by rst_n combinationally.
- IDLE arbitration (one cycle):
  - Only req_valid[0] high -> GNT0.
  - Only req_valid[1] high -> GNT1.
  - Both high -> GNT[prio].
  - Neither high -> stay IDLE.
  - The first beat can be accepted in the cycle after the request is seen in IDLE (1-cycle grant latency).
- In GNTi:
  - out_sel = i (registered; updated on entry to the state and held for the whole burst).
  - busy = 1.
  - out_valid = req_valid[i].
  - out_data = req_data_i (combinational mux on out_sel).
  - req_ready[i] = out_ready; req_ready[~i] = 0.
- Beat accepted = req_valid[i] && out_ready in GNTi; on each accepted beat beat_cnt increments.
- End of burst = an accepted beat with req_last[i] = 1 OR beat_cnt == MAX_BURST-1. On end of burst:
  - Next state = IDLE.
  - prio = ~i.
  - beat_cnt = 0.
- No direct grant-to-grant switch: there is always exactly one IDLE cycle between bursts.
- Requester dropping valid mid-burst:
  - The grant is held and out_valid is low (bubble).
  - There is no timeout.
  - The counter does not advance.
- out_ready low with valid high: stall, nothing changes, data must be held by the requester.
- Non-granted requester: its req_valid and req_last are ignored while the other holds the grant.
- req_last is sampled only with an accepted beat.
- out_sel stays at its last value in IDLE and is never X after reset.
- MAX_BURST = 1: every accepted beat ends the burst.

Test Plan:
- Reset then only req_valid = 2'b01, req_data0 = 8'hA5, req_last[0] = 1, out_ready = 1:
  - IDLE for 1 cycle, then GNT0 with out_sel = 0, out_data = 8'hA5, req_ready = 2'b01 for exactly 1 cycle.
  - Back to IDLE with prio = 1.
- Both valid continuously, req_last = 0, out_ready = 1, MAX_BURST = 4 -> repeating pattern:
  - 4 beats from requester 0, 1 IDLE cycle, 4 beats from requester 1, 1 IDLE cycle.
  - out_sel toggles 0 -> 1 -> 0.
- Downstream stall: in GNT1, out_ready low for 3 cycles after beat 1, then high:
  - out_data holds req_data1, req_ready = 2'b00 and beat_cnt = 1 during the stall.
  - Burst completes after 3 more accepted beats.
- Mid-burst valid drop:
  - In GNT0 after 2 beats, req_valid[0] goes low for 2 cycles while req_valid[1] is high.
  - Grant stays GNT0, out_valid = 0 and req_ready[1] = 0 during the drop.
  - Burst resumes and ends after beat 4.
- Reset mid-burst: assert rst_n = 0 for 1 cycle during beat 2 of GNT1:
  - Next cycle state = IDLE, out_sel = 0, prio = 0, busy = 0.
  - If both requesters are valid, the next grant goes to requester 0.
- req_last early: requester 1 asserts req_last on beat 2 with MAX_BURST = 4:
  - Burst ends after 2 beats, prio = 0.
  - Requester 0 is granted next, after the single IDLE cycle.
